// File: rtl/vec_mul_seq_ctrl.sv
// vec_mul_seq_ctrl: command sequencer for the 8x8 vector-multiply datapath.
// One start command optionally pops and reloads a weight tile, then streams
// num_vectors Unified Buffer addresses. The result-SRAM write strobe and
// address are produced by delaying the issue strobe by the datapath latency.
// Every output comes straight from a flop, so inputs never reach outputs
// combinationally.
module vec_mul_seq_ctrl #(
    parameter int ADDRESSSIZE = 10,
    parameter int PIPE_LAT    = 10
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   skip_weights,
    input  logic [ADDRESSSIZE-1:0] base_addr,
    input  logic [ADDRESSSIZE-1:0] num_vectors,
    input  logic [ADDRESSSIZE-1:0] res_base_addr,
    input  logic                   fifo_empty,
    output logic                   fifo_read_enable,
    output logic                   weight_reload,
    output logic [ADDRESSSIZE-1:0] sram_address,
    output logic                   issue_valid,
    output logic                   result_we,
    output logic [ADDRESSSIZE-1:0] result_address,
    output logic                   busy,
    output logic                   done,
    output logic                   cmd_error
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WPOP   = 3'd1,
        WWAIT  = 3'd2,
        WLOAD  = 3'd3,
        STREAM = 3'd4,
        DRAIN  = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDRESSSIZE-1:0] base_q, base_d;
    logic [ADDRESSSIZE-1:0] num_q, num_d;
    logic [ADDRESSSIZE-1:0] cnt_q, cnt_d;
    logic [ADDRESSSIZE-1:0] sram_address_q, sram_address_d;
    logic [ADDRESSSIZE-1:0] result_address_q, result_address_d;
    logic [PIPE_LAT-1:0]    dly_q, dly_d;
    logic                   fifo_read_enable_q, fifo_read_enable_d;
    logic                   weight_reload_q, weight_reload_d;
    logic                   issue_valid_q, issue_valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   cmd_error_q, cmd_error_d;

    // Next-state, run-parameter latching, address counters and latency shift line.
    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        num_d            = num_q;
        cnt_d            = cnt_q;
        sram_address_d   = sram_address_q;
        result_address_d = result_address_q;
        cmd_error_d      = 1'b0;
        // Issue strobe enters the bottom; the top bit is the aligned result strobe.
        dly_d            = (dly_q << 1) | PIPE_LAT'(issue_valid_q);

        // Result address advances after every write it was presented with.
        if (dly_q[PIPE_LAT-1]) begin
            result_address_d = result_address_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (!skip_weights && fifo_empty) begin
                        cmd_error_d = 1'b1;
                    end else begin
                        base_d           = base_addr;
                        num_d            = num_vectors;
                        result_address_d = res_base_addr;
                        if (!skip_weights) begin
                            state_d = WPOP;
                        end else if (num_vectors != '0) begin
                            state_d        = STREAM;
                            sram_address_d = base_addr;
                            cnt_d          = num_vectors - 1'b1;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end
            WPOP:  state_d = WWAIT;
            // One cycle for the FIFO's registered read data to settle.
            WWAIT: state_d = WLOAD;
            WLOAD: begin
                if (num_q != '0) begin
                    state_d        = STREAM;
                    sram_address_d = base_q;
                    cnt_d          = num_q - 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            STREAM: begin
                // cnt_q counts issues still to come after the current one.
                if (cnt_q == '0) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d          = cnt_q - 1'b1;
                    sram_address_d = sram_address_q + 1'b1;
                end
            end
            DRAIN: begin
                // Leave once no result strobe remains in flight after this edge.
                if (dly_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        fifo_read_enable_d = (state_d == WPOP);
        weight_reload_d    = (state_d == WLOAD);
        issue_valid_d      = (state_d == STREAM);
        busy_d             = (state_d != IDLE);
        done_d             = (state_d == DONE);
    end

    // State, counters and registered outputs; reset aborts any run in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q            <= IDLE;
            base_q             <= '0;
            num_q              <= '0;
            cnt_q              <= '0;
            sram_address_q     <= '0;
            result_address_q   <= '0;
            dly_q              <= '0;
            fifo_read_enable_q <= 1'b0;
            weight_reload_q    <= 1'b0;
            issue_valid_q      <= 1'b0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            cmd_error_q        <= 1'b0;
        end else begin
            state_q            <= state_d;
            base_q             <= base_d;
            num_q              <= num_d;
            cnt_q              <= cnt_d;
            sram_address_q     <= sram_address_d;
            result_address_q   <= result_address_d;
            dly_q              <= dly_d;
            fifo_read_enable_q <= fifo_read_enable_d;
            weight_reload_q    <= weight_reload_d;
            issue_valid_q      <= issue_valid_d;
            busy_q             <= busy_d;
            done_q             <= done_d;
            cmd_error_q        <= cmd_error_d;
        end
    end

    assign fifo_read_enable = fifo_read_enable_q;
    assign weight_reload    = weight_reload_q;
    assign sram_address     = sram_address_q;
    assign issue_valid      = issue_valid_q;
    assign result_we        = dly_q[PIPE_LAT-1];
    assign result_address   = result_address_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign cmd_error        = cmd_error_q;

endmodule
